dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL take parameter SETS, default 64, power of two: number of lines; cache is direct-mapped.
REQ-003 SHALL take parameter LINE_WORDS, default 4, power of two: 32-bit words per line.
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port rst  in  1: asynchronous, active-high reset.
REQ-006 Ports req_valid in 1, req_ready out 1: core request handshake.
REQ-007 Ports req_we in 1, req_width in 2, req_sign in 1, req_addr in ADDR_W, req_wdata in 32: store flag, width (00 byte, 01 half, 10 word), load sign-extend, address, store data.
REQ-008 Ports resp_valid out 1, resp_rdata out 32, resp_err out 1: one-cycle completion pulse, load data, misalignment error.
REQ-009 Ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_wstrb out 4: single-word memory request, held stable until accepted.
REQ-010 Ports mem_ack in 1, mem_rdata in 32: memory accepts the request and returns read data in the same cycle.

Function
REQ-011 A request SHALL be accepted when req_valid and req_ready are both high; req_ready SHALL be high only in IDLE.
REQ-012 FSM states SHALL be IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE -> LOOKUP on an accepted request; all request fields are registered.
REQ-013 Misaligned accesses SHALL complete from LOOKUP via RESP with resp_err=1, no memory traffic, and no cache change.
- Half-word misaligned: addr[0]=1.
- Word misaligned: addr[1:0]!=0.
- Width 11 SHALL also be treated as an error.
REQ-014 Load hit (valid and tag match) SHALL go LOOKUP -> RESP; resp_valid SHALL be high 2 cycles after acceptance.
REQ-015 Load miss SHALL go LOOKUP -> REFILL.
- REFILL fetches LINE_WORDS words, critical word first, wrapping modulo LINE_WORDS within the line.
- One word is written per mem_ack.
- After the last word, the line becomes valid with the new tag and the FSM goes to RESP.
REQ-016 Stores SHALL be write-through, no-write-allocate.
- LOOKUP -> WRITE; mem_we=1; mem_wstrb from width and addr[1:0]; mem_wdata is the store data replicated into the addressed lanes.
- On a hit, the addressed bytes of the cached word are updated in the same cycle as mem_ack.
- On a miss, the cache is unchanged.
- WRITE -> RESP on mem_ack.
REQ-017 Load data SHALL select the byte or half-word by addr[1:0] and zero- or sign-extend it per req_sign; a word load returns the whole word.
REQ-018 In RESP, resp_valid=1 for exactly one cycle, then the FSM returns to IDLE; resp_rdata=0 for stores and errors.
REQ-019 mem_addr SHALL be word-aligned (bits[1:0]=0) during REFILL and WRITE.
REQ-020 mem_req SHALL be asserted only in REFILL and WRITE, and SHALL stay asserted with unchanged outputs while mem_ack is low.

Reset
REQ-021 On rst, all valid bits SHALL clear and the FSM SHALL enter IDLE.
- Outputs: req_ready=1 after release; resp_valid=0, resp_err=0, mem_req=0, mem_we=0, mem_wstrb=0, resp_rdata=0, mem_addr=0, mem_wdata=0.
REQ-022 Reset during REFILL SHALL leave the partially filled line invalid; an in-flight request is dropped with no response.
REQ-023 Tag and data arrays need no reset.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the width codes (BYTE=00, HALF=01, WORD=10), and the address field-split helper constants.
REQ-025 A sub-module dcache_ld_align SHALL implement load extraction/extension and store strobe/lane generation; the data array is a plain register array.

Verification
REQ-026 Cold load word at 0x100, memory returns 0x11111111..0x44444444 for 0x100..0x10C -> 4 refill acks starting at 0x100, resp_rdata=0x11111111.
REQ-027 Load word at 0x108 after REQ-026 -> hit, no mem_req, resp_valid exactly 2 cycles after acceptance, rdata=0x33333333.
REQ-028 Load at 0x10B of word 0x80FF7F01:
- byte, sign=1 -> 0xFFFFFF80.
- byte, sign=0 -> 0x00000080.
- half at 0x10A, sign=1 -> 0xFFFF80FF.
REQ-029 Store byte 0xAB at 0x105 (hit) -> mem_wstrb=0010, mem_wdata=0xABABABAB; a following load word at 0x104 returns 0x2222AB22.
REQ-030 Load word at 0x102 -> resp_err=1, no mem_req; cold miss at 0x20C -> refill order 0x20C, 0x200, 0x204, 0x208; rst asserted mid-refill -> a reload of 0x20C misses.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-through dcache.
// FSM encoding, access width codes and address-split helpers.
package dcache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam int OFF_W = 2;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_bits(input int addr_w,
                                  input int sets,
                                  input int line_words);
    return addr_w - OFF_W - $clog2(line_words) - $clog2(sets);
  endfunction

  function automatic logic misaligned(input logic [1:0] w,
                                      input logic [1:0] off);
    logic r;
    r = 1'b1;
    unique case (w)
      W_BYTE: r = 1'b0;
      W_HALF: r = off[0];
      W_WORD: r = |off;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Core-side and memory-side bundles of the dcache controller.
// The core masters requests; the cache masters the memory bus.
interface dcache_core_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_width;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_width,
    output req_sign, req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_width,
    input  req_sign, req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

interface dcache_mem_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_ld_align.sv
// Load byte/half extraction with extension, and store
// strobe/lane replication for the addressed bytes.
module dcache_ld_align
  import dcache_ctrl_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic        i_sign,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wlanes
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_ldata  = '0;
    o_wstrb  = '0;
    o_wlanes = '0;
    unique case (1'b1)
      (i_width == W_BYTE): begin
        o_ldata  = {{24{i_sign & w_byte[7]}}, w_byte};
        o_wstrb  = 4'b0001 << i_off;
        o_wlanes = {4{i_wdata[7:0]}};
      end
      (i_width == W_HALF): begin
        o_ldata  = {{16{i_sign & w_half[15]}}, w_half};
        o_wstrb  = i_off[1] ? 4'b1100 : 4'b0011;
        o_wlanes = {2{i_wdata[15:0]}};
      end
      (i_width == W_WORD): begin
        o_ldata  = i_word;
        o_wstrb  = 4'b1111;
        o_wlanes = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache
// with critical-word-first line refill over a one-word bus.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_core_if.slave core,
  dcache_mem_if.master mem
);

  localparam int WB = word_bits(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = tag_bits(ADDR_W, SETS, LINE_WORDS);

  state_e r_state;
  state_e w_next;

  logic              r_we;
  logic              r_sign;
  logic [1:0]        r_width;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [WB-1:0]     r_cnt;
  logic [WB-1:0]     r_widx;

  logic [SETS-1:0] r_valid;
  logic [TB-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS][LINE_WORDS];

  logic [TB-1:0] w_tag;
  logic [IB-1:0] w_idx;
  logic [WB-1:0] w_word;
  logic [1:0]    w_off;
  logic          w_hit;
  logic          w_err;
  logic          w_last;
  logic          w_ack;
  logic [31:0]   w_aword;
  logic [31:0]   w_ldata;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wlanes;

  assign w_tag  = r_addr[ADDR_W-1 -: TB];
  assign w_idx  = r_addr[OFF_W+WB +: IB];
  assign w_word = r_addr[OFF_W +: WB];
  assign w_off  = r_addr[1:0];
  assign w_hit  = r_valid[w_idx] &&
                  (r_tag[w_idx] == w_tag);
  assign w_err  = misaligned(r_width, w_off);
  assign w_last = (r_cnt == WB'(LINE_WORDS-1));
  assign w_ack  = mem.mem_ack;

  // During refill the word being extracted comes straight off the bus.
  assign w_aword = (r_state == S_REFILL) ?
                   mem.mem_rdata :
                   r_data[w_idx][w_word];

  dcache_ld_align u_align (
    .i_width  (r_width),
    .i_sign   (r_sign),
    .i_off    (w_off),
    .i_word   (w_aword),
    .i_wdata  (r_wdata),
    .o_ldata  (w_ldata),
    .o_wstrb  (w_wstrb),
    .o_wlanes (w_wlanes)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_width <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_widx  <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          r_err   <= 1'b0;
          r_rdata <= '0;
          if (core.req_valid) begin
            r_we    <= core.req_we;
            r_sign  <= core.req_sign;
            r_width <= core.req_width;
            r_addr  <= core.req_addr;
            r_wdata <= core.req_wdata;
          end
        end
        S_LOOKUP: begin
          r_err  <= w_err;
          r_cnt  <= '0;
          r_widx <= w_word;
          if (!w_err && !r_we) begin
            if (w_hit) r_rdata <= w_ldata;
            else r_valid[w_idx] <= 1'b0;
          end
        end
        S_REFILL: begin
          if (w_ack) begin
            r_cnt  <= r_cnt + WB'(1);
            r_widx <= r_widx + WB'(1);
            if (r_widx == w_word) r_rdata <= w_ldata;
            if (w_last) r_valid[w_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && w_ack) begin
      r_data[w_idx][r_widx] <= mem.mem_rdata;
      if (w_last) r_tag[w_idx] <= w_tag;
    end
    if (r_state == S_WRITE && w_ack && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wstrb[b])
          r_data[w_idx][w_word][8*b +: 8] <=
            w_wlanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (core.req_valid) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_err)      w_next = S_RESP;
        else if (r_we)  w_next = S_WRITE;
        else if (w_hit) w_next = S_RESP;
        else            w_next = S_REFILL;
      end
      S_REFILL:
        if (w_ack && w_last) w_next = S_RESP;
      S_WRITE:
        if (w_ack) w_next = S_RESP;
      S_RESP:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    core.req_ready  = 1'b0;
    core.resp_valid = 1'b0;
    core.resp_rdata = '0;
    core.resp_err   = 1'b0;
    mem.mem_req     = 1'b0;
    mem.mem_we      = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_wdata   = '0;
    mem.mem_wstrb   = '0;
    unique case (r_state)
      S_IDLE:
        core.req_ready = !rst;
      S_REFILL: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {w_tag, w_idx, r_widx, 2'b00};
      end
      S_WRITE: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem.mem_wdata = w_wlanes;
        mem.mem_wstrb = w_wstrb;
      end
      S_RESP: begin
        core.resp_valid = 1'b1;
        core.resp_rdata = r_rdata;
        core.resp_err   = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed and random checks of dcache_ctrl against a
// set-level hit model and a byte-addressed memory model.
module tb_dcache_ctrl;

  localparam int LW = 4;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  s;
    logic [31:0] d;
  } txn_t;

  logic clk;
  logic rst;

  dcache_core_if #(.ADDR_W(32)) core_if ();
  dcache_mem_if  #(.ADDR_W(32)) mem_if ();

  dcache_ctrl #(
    .ADDR_W     (32),
    .SETS       (64),
    .LINE_WORDS (LW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .mem  (mem_if)
  );

  int n_vec = 0;
  int n_err = 0;

  txn_t        q[$];
  logic [31:0] mem_m [logic [31:0]];
  bit          mv [64];
  logic [21:0] mt [64];

  bit          pend = 0;
  logic [31:0] p_a, p_d;
  logic        p_we;
  logic [3:0]  p_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    if (a >= 32'h100 && a <= 32'h10C)
      return 32'h11111111 * ((a - 32'h100) / 4 + 1);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic wr_mem(input logic [31:0] a,
                        input logic [3:0] s,
                        input logic [31:0] d);
    logic [31:0] v;
    v = rd_mem(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_m[a] = v;
  endtask

  // Memory responder: random ack, hold and alignment checks.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      mem_if.mem_ack = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_req", {31'b0, mem_if.mem_req}, 1);
        chk("hold_addr", mem_if.mem_addr, p_a);
        chk("hold_we", {31'b0, mem_if.mem_we}, {31'b0, p_we});
        chk("hold_strb", {28'b0, mem_if.mem_wstrb}, {28'b0, p_s});
        chk("hold_wdata", mem_if.mem_wdata, p_d);
      end
      if (mem_if.mem_req)
        chk("addr_align", {30'b0, mem_if.mem_addr[1:0]}, 0);
      mem_if.mem_ack = mem_if.mem_req &&
                       ($urandom_range(0, 2) != 0);
      mem_if.mem_rdata = mem_if.mem_ack ?
                         rd_mem(mem_if.mem_addr) :
                         32'hDEADBEEF;
      if (mem_if.mem_ack) begin
        q.push_back('{mem_if.mem_addr, mem_if.mem_we,
                      mem_if.mem_wstrb, mem_if.mem_wdata});
        if (mem_if.mem_we)
          wr_mem(mem_if.mem_addr, mem_if.mem_wstrb,
                 mem_if.mem_wdata);
      end
      pend = mem_if.mem_req && !mem_if.mem_ack;
      p_a  = mem_if.mem_addr;
      p_we = mem_if.mem_we;
      p_s  = mem_if.mem_wstrb;
      p_d  = mem_if.mem_wdata;
    end
  end

  task automatic do_req(input logic we,
                        input logic [1:0] w,
                        input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input string tag,
                        output logic [31:0] rd);
    logic [31:0] base, line, word, exp_d, el, ea[$];
    logic [3:0]  es;
    logic [1:0]  off;
    logic [21:0] tg;
    bit err, hit, got;
    int idx, lat, t;
    off  = a[1:0];
    base = {a[31:2], 2'b00};
    line = {a[31:4], 4'b0000};
    idx  = int'(a[9:4]);
    tg   = a[31:10];
    err  = (w == 2'd3) || (w == 2'd1 && a[0]) ||
           (w == 2'd2 && off != 0);
    hit  = mv[idx] && mt[idx] == tg;
    es   = (w == 0) ? 4'(1 << off) :
           (w == 1) ? (off[1] ? 4'hC : 4'h3) : 4'hF;
    el   = (w == 0) ? {4{wd[7:0]}} :
           (w == 1) ? {2{wd[15:0]}} : wd;
    word  = rd_mem(base);
    exp_d = 0;
    if (!err && !we) begin
      if (w == 0) begin
        exp_d = (word >> (8 * off)) & 32'hFF;
        if (sg && exp_d[7]) exp_d |= 32'hFFFFFF00;
      end else if (w == 1) begin
        exp_d = (word >> (8 * off)) & 32'hFFFF;
        if (sg && exp_d[15]) exp_d |= 32'hFFFF0000;
      end else exp_d = word;
      if (!hit)
        for (int k = 0; k < LW; k++)
          ea.push_back(line + ((int'(a[3:2]) + k) % LW) * 4);
    end
    if (!err && we) ea.push_back(base);
    q.delete();
    t = 0;
    while (!core_if.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    core_if.req_valid = 1'b1;
    core_if.req_we    = we;
    core_if.req_width = w;
    core_if.req_sign  = sg;
    core_if.req_addr  = a;
    core_if.req_wdata = wd;
    @(posedge clk);
    #1 core_if.req_valid = 1'b0;
    lat = 0;
    got = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1)
        chk({tag, "_busy"}, {31'b0, core_if.req_ready}, 0);
      if (core_if.resp_valid) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_done"}, {31'b0, got}, 1);
    rd = core_if.resp_rdata;
    if (got) begin
      chk({tag, "_err"}, {31'b0, core_if.resp_err}, {31'b0, err});
      chk({tag, "_rdata"}, core_if.resp_rdata, exp_d);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'b0, core_if.resp_valid}, 0);
    end
    chk({tag, "_ntxn"}, q.size(), ea.size());
    for (int k = 0; k < ea.size() && k < q.size(); k++) begin
      chk({tag, "_maddr"}, q[k].a, ea[k]);
      chk({tag, "_mwe"}, {31'b0, q[k].we}, {31'b0, we});
      if (we) begin
        chk({tag, "_mstrb"}, {28'b0, q[k].s}, {28'b0, es});
        chk({tag, "_mwdata"}, q[k].d, el);
      end
    end
    if (hit && !err && !we)
      chk({tag, "_lat"}, lat, 2);
    if (!err && !we && !hit) begin
      mv[idx] = 1;
      mt[idx] = tg;
    end
  endtask

  initial begin
    logic [31:0] rd, ra, rw;
    logic [1:0]  rwd;
    logic        rwe, rsg;
    int t;
    rst = 1'b1;
    core_if.req_valid = 1'b0;
    core_if.req_we    = 1'b0;
    core_if.req_width = 2'b00;
    core_if.req_sign  = 1'b0;
    core_if.req_addr  = '0;
    core_if.req_wdata = '0;
    mem_if.mem_ack    = 1'b0;
    mem_if.mem_rdata  = '0;
    for (int i = 0; i < 64; i++) mv[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'b0, core_if.resp_valid}, 0);
    chk("rst_resp_err", {31'b0, core_if.resp_err}, 0);
    chk("rst_resp_rdata", core_if.resp_rdata, 0);
    chk("rst_mem_req", {31'b0, mem_if.mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_if.mem_we}, 0);
    chk("rst_mem_wstrb", {28'b0, mem_if.mem_wstrb}, 0);
    chk("rst_mem_addr", mem_if.mem_addr, 0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, core_if.req_ready}, 1);

    do_req(0, 2'd2, 0, 32'h100, 0, "cold100", rd);
    chk("cold100_val", rd, 32'h11111111);
    do_req(0, 2'd2, 0, 32'h108, 0, "hit108", rd);
    chk("hit108_val", rd, 32'h33333333);
    do_req(1, 2'd2, 0, 32'h108, 32'h80FF7F01, "stw108", rd);
    do_req(0, 2'd0, 1, 32'h10B, 0, "lbs10B", rd);
    chk("lbs10B_val", rd, 32'hFFFFFF80);
    do_req(0, 2'd0, 0, 32'h10B, 0, "lbu10B", rd);
    chk("lbu10B_val", rd, 32'h00000080);
    do_req(0, 2'd1, 1, 32'h10A, 0, "lhs10A", rd);
    chk("lhs10A_val", rd, 32'hFFFF80FF);
    do_req(1, 2'd0, 0, 32'h105, 32'h000000AB, "stb105", rd);
    do_req(0, 2'd2, 0, 32'h104, 0, "lw104", rd);
    chk("lw104_val", rd, 32'h2222AB22);
    do_req(0, 2'd2, 0, 32'h102, 0, "mis102", rd);
    do_req(0, 2'd1, 0, 32'h101, 0, "mish101", rd);
    do_req(0, 2'd3, 0, 32'h100, 0, "w11", rd);
    do_req(0, 2'd2, 0, 32'h20C, 0, "cold20C", rd);

    q.delete();
    core_if.req_valid = 1'b1;
    core_if.req_we    = 1'b0;
    core_if.req_width = 2'd2;
    core_if.req_addr  = 32'h30C;
    @(posedge clk);
    #1 core_if.req_valid = 1'b0;
    t = 0;
    while (q.size() < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("midfill_started", {31'b0, q.size() >= 2}, 1);
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", {31'b0, mem_if.mem_req}, 0);
    chk("midrst_resp", {31'b0, core_if.resp_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mv[i] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_noresp", {31'b0, core_if.resp_valid}, 0);
      chk("midrst_ready", {31'b0, core_if.req_ready}, 1);
    end
    do_req(0, 2'd2, 0, 32'h30C, 0, "re30C", rd);
    do_req(0, 2'd2, 0, 32'h20C, 0, "re20C", rd);

    for (int i = 0; i < 80; i++) begin
      ra  = ($urandom_range(0, 3) << 10) |
            ($urandom_range(16, 19) << 4) |
            $urandom_range(0, 15);
      rwe = ($urandom_range(0, 2) == 0);
      rwd = 2'($urandom_range(0, 3));
      rsg = 1'($urandom_range(0, 1));
      rw  = $urandom;
      do_req(rwe, rwd, rsg, ra, rw, "rnd", rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
